// File: rtl/key_pkg.sv
// key_pkg: shared state encoding, default timing constants and counter sizing
// helpers for the push-button conditioner (key_fsm / key_conditioner).
package key_pkg;

  // Default timing at a 50 MHz clock
  localparam int DEF_N_KEYS        = 3;
  localparam int DEF_DEB_CYCLES    = 500000;    // 10 ms debounce window
  localparam int DEF_LONG_CYCLES   = 50000000;  // 1 s hold before long press
  localparam int DEF_REPEAT_CYCLES = 10000000;  // 200 ms auto-repeat period

  // Per-key conditioner states; ST_REPEAT is only reachable with KEY_REPEAT_EN
  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_DEB_PRESS   = 3'd1,
    ST_HELD        = 3'd2,
    ST_DEB_RELEASE = 3'd3,
    ST_REPEAT      = 3'd4
  } key_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return m;
  endfunction

  // One counter serves debounce, hold and repeat timing, so it is sized for
  // the longest of the three intervals.
  function automatic int cnt_width(input int deb, input int lng, input int rep);
    return $clog2(max3(deb, lng, rep) + 1);
  endfunction

endpackage

// File: rtl/key_fsm.sv
// key_fsm: conditioner for a single push-button. Synchronizes the raw
// active-low input, debounces press and release, and generates one-cycle
// press / release / long-press pulses. With KEY_REPEAT_EN defined, a held key
// also emits auto-repeat pulses after the long press; otherwise key_repeat is 0.
import key_pkg::*;

module key_fsm #(
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic key_level,
  output logic press,
  output logic key_release,
  output logic long_press,
  output logic key_repeat
);

  localparam int CW = cnt_width(DEB_CYCLES, LONG_CYCLES, REPEAT_CYCLES);
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t CNT_ZERO  = {CW{1'b0}};
  localparam cnt_t CNT_ONE   = cnt_t'(1'b1);
  localparam cnt_t CNT_MAX   = {CW{1'b1}};
  localparam cnt_t DEB_LAST  = cnt_t'(DEB_CYCLES - 1);
  localparam cnt_t LONG_LAST = cnt_t'(LONG_CYCLES - 1);
  localparam cnt_t LONG_SAT  = cnt_t'(LONG_CYCLES);
`ifdef KEY_REPEAT_EN
  localparam cnt_t REP_LAST  = cnt_t'(REPEAT_CYCLES - 1);
`endif

  logic       sync1_r;
  logic       sync2_r;
  logic       pressed_s;
  key_state_e state_r;
  key_state_e state_s;
  cnt_t       cnt_r;
  cnt_t       cnt_s;
  cnt_t       cnt_inc_s;
  logic       long_sent_r;
  logic       long_sent_s;
  logic       level_s;
  logic       press_s;
  logic       release_s;
  logic       long_s;
  logic       repeat_s;

  // Two-flop synchronizer; idles at 1 (released) so reset never looks like a press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= key_n;
      sync2_r <= sync1_r;
    end
  end

  assign pressed_s = ~sync2_r;
  assign cnt_inc_s = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);

  // Next-state, counter and pulse decode for the debounce/hold state machine
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    long_sent_s = long_sent_r;
    level_s     = key_level;
    press_s     = 1'b0;
    release_s   = 1'b0;
    long_s      = 1'b0;
    repeat_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pressed_s) begin
          state_s = ST_DEB_PRESS;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DEB_PRESS: begin
        if (!pressed_s) begin
          state_s = ST_IDLE;
        end else if (cnt_r == DEB_LAST) begin
          state_s     = ST_HELD;
          cnt_s       = CNT_ZERO;
          level_s     = 1'b1;
          press_s     = 1'b1;
          long_sent_s = 1'b0;
        end else begin
          cnt_s = cnt_inc_s;
        end
      end
      ST_HELD: begin
        if (!pressed_s) begin
          state_s = ST_DEB_RELEASE;
          cnt_s   = CNT_ZERO;
        end else if (!long_sent_r && (cnt_r == LONG_LAST)) begin
          long_s      = 1'b1;
          long_sent_s = 1'b1;
`ifdef KEY_REPEAT_EN
          state_s     = ST_REPEAT;
          cnt_s       = CNT_ZERO;
`else
          cnt_s       = LONG_SAT;
`endif
        end else if (cnt_r != LONG_SAT) begin
          cnt_s = cnt_inc_s;
        end else begin
          cnt_s = cnt_r;
        end
      end
`ifdef KEY_REPEAT_EN
      ST_REPEAT: begin
        if (!pressed_s) begin
          state_s = ST_DEB_RELEASE;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r == REP_LAST) begin
          repeat_s = 1'b1;
          cnt_s    = CNT_ZERO;
        end else begin
          cnt_s = cnt_inc_s;
        end
      end
`endif
      ST_DEB_RELEASE: begin
        if (pressed_s) begin
          // Bounce: resume holding; long_sent_r is kept so no second long press
`ifdef KEY_REPEAT_EN
          state_s = long_sent_r ? ST_REPEAT : ST_HELD;
`else
          state_s = ST_HELD;
`endif
          cnt_s   = CNT_ZERO;
        end else if (cnt_r == DEB_LAST) begin
          state_s     = ST_IDLE;
          cnt_s       = CNT_ZERO;
          level_s     = 1'b0;
          release_s   = 1'b1;
          long_sent_s = 1'b0;
        end else begin
          cnt_s = cnt_inc_s;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        cnt_s       = CNT_ZERO;
        level_s     = 1'b0;
        long_sent_s = 1'b0;
      end
    endcase
  end

  // State, counter and registered outputs; reset discards any pending event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= CNT_ZERO;
      long_sent_r <= 1'b0;
      key_level   <= 1'b0;
      press       <= 1'b0;
      key_release <= 1'b0;
      long_press  <= 1'b0;
      key_repeat  <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      long_sent_r <= long_sent_s;
      key_level   <= level_s;
      press       <= press_s;
      key_release <= release_s;
      long_press  <= long_s;
      key_repeat  <= repeat_s;
    end
  end

endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: N_KEYS independent push-button conditioners, one key_fsm
// per button. Auto-repeat is selected at build time with KEY_REPEAT_EN.
import key_pkg::*;

module key_conditioner #(
  parameter int N_KEYS        = DEF_N_KEYS,
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] long_press,
  output logic [N_KEYS-1:0] key_repeat
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_fsm #(
      .DEB_CYCLES    (DEB_CYCLES),
      .LONG_CYCLES   (LONG_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_key_fsm (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_n       (key_n[i]),
      .key_level   (key_level[i]),
      .press       (press[i]),
      .key_release (key_release[i]),
      .long_press  (long_press[i]),
      .key_repeat  (key_repeat[i])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner with short timing (DEB=4, LONG=20, REPEAT=6):
// a directed vector table, hand sequences for reset and auto-repeat, and a
// randomized run against a run-length reference model.
module tb_key_conditioner;

  localparam int NK   = 3;
  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int REP  = 6;
`ifdef KEY_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NK-1:0] key_n;
  logic [NK-1:0] key_level;
  logic [NK-1:0] press;
  logic [NK-1:0] key_release;
  logic [NK-1:0] long_press;
  logic [NK-1:0] key_repeat;

  int checks = 0;
  int errors = 0;

  key_conditioner #(
    .N_KEYS(NK), .DEB_CYCLES(DEB), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_n(key_n), .key_level(key_level),
    .press(press), .key_release(key_release), .long_press(long_press),
    .key_repeat(key_repeat)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Reference model: per key, the debounced level flips once DEB+1 consecutive
  // synchronized samples disagree with it; hold time is counted in pressed
  // samples since the press or since the last bounce ended.
  int opp_run [NK];
  int hold_run[NK];
  bit lvl     [NK];
  bit lsent   [NK];
  bit d1      [NK];
  bit d2      [NK];

  task automatic model_reset();
    for (int k = 0; k < NK; k++) begin
      opp_run[k] = 0; hold_run[k] = 0; lvl[k] = 1'b0; lsent[k] = 1'b0;
      d1[k] = 1'b0; d2[k] = 1'b0;
    end
  endtask

  task automatic model_step(input logic [NK-1:0] kn, output logic [5*NK-1:0] exp);
    logic [NK-1:0] e_lvl, e_prs, e_rel, e_lng, e_rep;
    bit v;
    e_prs = '0; e_rel = '0; e_lng = '0; e_rep = '0;
    for (int k = 0; k < NK; k++) begin
      v = d2[k];
      if (v != lvl[k]) begin
        opp_run[k]++;
        if (opp_run[k] == DEB + 1) begin
          if (!lvl[k]) e_prs[k] = 1'b1;
          else         e_rel[k] = 1'b1;
          lvl[k] = ~lvl[k];
          opp_run[k] = 0; hold_run[k] = 0; lsent[k] = 1'b0;
        end
      end else if (lvl[k]) begin
        if (opp_run[k] != 0) begin
          opp_run[k] = 0; hold_run[k] = 0;
        end else begin
          hold_run[k]++;
          if (!lsent[k] && hold_run[k] == LONG) begin
            e_lng[k] = 1'b1; lsent[k] = 1'b1; hold_run[k] = 0;
          end else if (lsent[k] && REP_EN && hold_run[k] == REP) begin
            e_rep[k] = 1'b1; hold_run[k] = 0;
          end
        end
      end else begin
        opp_run[k] = 0;
      end
      e_lvl[k] = lvl[k];
      d2[k] = d1[k];
      d1[k] = ~kn[k];
    end
    exp = {e_lvl, e_prs, e_rel, e_lng, e_rep};
  endtask

  typedef struct {
    logic [2:0] kn;
    int         n;
    logic [2:0] lvl;
    logic [2:0] prs;
    logic [2:0] rel;
    logic [2:0] lng;
  } vec_t;

  vec_t tbl[18];

  initial begin
    logic [5*NK-1:0] exp_v;
    int remain[NK];
    bit exp_l, exp_r;

    tbl[0]  = '{3'b110,  6, 3'b000, 3'b000, 3'b000, 3'b000};
    tbl[1]  = '{3'b110,  1, 3'b001, 3'b001, 3'b000, 3'b000};
    tbl[2]  = '{3'b100,  3, 3'b001, 3'b000, 3'b000, 3'b000};
    tbl[3]  = '{3'b110,  6, 3'b001, 3'b000, 3'b000, 3'b000};
    tbl[4]  = '{3'b110, 10, 3'b001, 3'b000, 3'b000, 3'b000};
    tbl[5]  = '{3'b110,  1, 3'b001, 3'b000, 3'b000, 3'b001};
    tbl[6]  = '{3'b110,  1, 3'b001, 3'b000, 3'b000, 3'b000};
    tbl[7]  = '{3'b111,  2, 3'b001, 3'b000, 3'b000, 3'b000};
    tbl[8]  = '{3'b110,  8, 3'b001, 3'b000, 3'b000, 3'b000};
    tbl[9]  = '{3'b111,  5, 3'b001, 3'b000, 3'b000, 3'b000};
    tbl[10] = '{3'b111,  1, 3'b001, 3'b000, 3'b000, 3'b000};
    tbl[11] = '{3'b111,  1, 3'b000, 3'b000, 3'b001, 3'b000};
    tbl[12] = '{3'b111,  1, 3'b000, 3'b000, 3'b000, 3'b000};
    tbl[13] = '{3'b010,  6, 3'b000, 3'b000, 3'b000, 3'b000};
    tbl[14] = '{3'b010,  1, 3'b101, 3'b101, 3'b000, 3'b000};
    tbl[15] = '{3'b010,  1, 3'b101, 3'b000, 3'b000, 3'b000};
    tbl[16] = '{3'b111,  6, 3'b101, 3'b000, 3'b000, 3'b000};
    tbl[17] = '{3'b111,  1, 3'b000, 3'b000, 3'b101, 3'b000};

    // Reset state
    key_n = 3'b111;
    rst_n = 1'b0;
    tick();
    check("reset_outputs", {key_level, press, key_release, long_press, key_repeat}, 32'h0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Directed vector table: press latency, short glitch, long press, bounce, release
    for (int i = 0; i < 18; i++) begin
      key_n = tbl[i].kn;
      repeat (tbl[i].n) tick();
      check($sformatf("vec%0d", i), {key_level, press, key_release, long_press},
            {tbl[i].lvl, tbl[i].prs, tbl[i].rel, tbl[i].lng});
    end

    // Reset while a key is held: outputs clear at once, no release, press re-fires
    key_n = 3'b111;
    do_reset();
    key_n = 3'b110;
    repeat (10) tick();
    check("hold_before_rst", key_level, 3'b001);
    #2 rst_n = 1'b0;
    #1;
    check("rst_immediate", {key_level, press, key_release, long_press, key_repeat}, 32'h0);
    tick();
    tick();
    check("rst_no_release", key_release, 3'b000);
    rst_n = 1'b1;
    repeat (6) tick();
    check("rst_repress_early", {key_level, press, key_release}, 32'h0);
    tick();
    check("rst_repress", {key_level, press, key_release}, {3'b001, 3'b001, 3'b000});

    // Long press and auto-repeat timing over a 50-edge hold
    key_n = 3'b111;
    do_reset();
    key_n = 3'b110;
    for (int e = 0; e <= 50; e++) begin
      tick();
      exp_l = (e == 26);
      exp_r = REP_EN && (e >= 32) && (((e - 26) % REP) == 0);
      check($sformatf("hold_edge%0d", e), {long_press[0], key_repeat[0]}, {exp_l, exp_r});
    end

    // Randomized bursts on all keys against the reference model
    key_n = 3'b111;
    do_reset();
    model_reset();
    for (int k = 0; k < NK; k++) remain[k] = $urandom_range(1, 8);
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < NK; k++) begin
        if (remain[k] == 0) begin
          key_n[k] = ~key_n[k];
          remain[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 70) : $urandom_range(1, 8);
        end else begin
          remain[k]--;
        end
      end
      tick();
      model_step(key_n, exp_v);
      check($sformatf("rand%0d", c), {key_level, press, key_release, long_press, key_repeat}, exp_v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
